// File: rtl/alert_driver.sv
// rtl/alert_driver.sv - LED indicators and timed piezo beep patterns driven from debounced key levels
module alert_driver #(
    parameter int TONE_DIV = 25000,
    parameter int BEEP_LEN = 5000000,
    parameter int GAP_LEN  = 2500000,
    parameter int CNT_W    = 23
) (
    input  logic clk_50MHz,
    input  logic reset,
    input  logic key_on,
    input  logic key_off,
    input  logic key_err,
    input  logic key_open,
    input  logic key_buzzer,
    output logic led_on,
    output logic led_err,
    output logic led_open,
    output logic buzzer_out,
    output logic busy
);

    localparam int TW = $clog2(TONE_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [1:0]       beeps_left, beeps_n;
    logic [CNT_W-1:0] dur_cnt, dur_n;
    logic [TW-1:0]    tone_cnt, tone_n;
    logic             buz_n;

    logic prev_on, prev_off, prev_err, prev_buzzer;
    logic ev_on, ev_off, ev_err, ev_buzzer;
    logic pat_ev;
    logic [1:0] pat_cnt;

    assign ev_on     = key_on & ~prev_on;
    assign ev_off    = key_off & ~prev_off;
    assign ev_err    = key_err & ~prev_err;
    assign ev_buzzer = key_buzzer & ~prev_buzzer;
    assign pat_ev    = ev_err | ev_off | ev_on | ev_buzzer;
    assign busy      = (state != IDLE);

    // Beep count of the highest-priority event this cycle (err > off > on > buzzer)
    always_comb begin
        pat_cnt = 2'd1;
        if (ev_err) begin
            pat_cnt = 2'd3;
        end else if (ev_off) begin
            pat_cnt = 2'd2;
        end
    end

    // Edge-detect history and LED indicators
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            prev_on     <= 1'b0;
            prev_off    <= 1'b0;
            prev_err    <= 1'b0;
            prev_buzzer <= 1'b0;
            led_on      <= 1'b0;
            led_err     <= 1'b0;
            led_open    <= 1'b0;
        end else begin
            prev_on     <= key_on;
            prev_off    <= key_off;
            prev_err    <= key_err;
            prev_buzzer <= key_buzzer;
            led_open    <= key_open;
            // off beats on when both arrive together
            if (ev_off) begin
                led_on <= 1'b0;
            end else if (ev_on) begin
                led_on <= 1'b1;
            end
            // a fresh error survives a simultaneous off
            if (ev_err) begin
                led_err <= 1'b1;
            end else if (ev_off) begin
                led_err <= 1'b0;
            end
        end
    end

    // Pattern sequencer: next state, counters and tone level
    always_comb begin
        state_n = state;
        beeps_n = beeps_left;
        dur_n   = dur_cnt;
        tone_n  = tone_cnt;
        buz_n   = buzzer_out;
        case (state)
            IDLE: begin
                buz_n = 1'b0;
                if (pat_ev) begin
                    state_n = BEEP;
                    beeps_n = pat_cnt;
                    dur_n   = '0;
                    tone_n  = '0;
                    buz_n   = 1'b1;
                end
            end
            BEEP: begin
                if (tone_cnt == TW'(TONE_DIV - 1)) begin
                    tone_n = '0;
                    buz_n  = ~buzzer_out;
                end else begin
                    tone_n = tone_cnt + TW'(1);
                end
                if (dur_cnt == CNT_W'(BEEP_LEN - 1)) begin
                    buz_n   = 1'b0;
                    dur_n   = '0;
                    beeps_n = beeps_left - 2'd1;
                    state_n = (beeps_left == 2'd1) ? IDLE : GAP;
                end else begin
                    dur_n = dur_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                buz_n = 1'b0;
                if (dur_cnt == CNT_W'(GAP_LEN - 1)) begin
                    state_n = BEEP;
                    dur_n   = '0;
                    tone_n  = '0;
                    buz_n   = 1'b1;
                end else begin
                    dur_n = dur_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                buz_n   = 1'b0;
            end
        endcase
        // an error restarts any running pattern from its first beep
        if (state != IDLE && ev_err) begin
            state_n = BEEP;
            beeps_n = 2'd3;
            dur_n   = '0;
            tone_n  = '0;
            buz_n   = 1'b1;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beeps_left <= 2'd0;
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            buzzer_out <= 1'b0;
        end else begin
            state      <= state_n;
            beeps_left <= beeps_n;
            dur_cnt    <= dur_n;
            tone_cnt   <= tone_n;
            buzzer_out <= buz_n;
        end
    end

endmodule

// File: tb/tb_alert_driver.sv
// tb/tb_alert_driver.sv - scoreboard bench for alert_driver beep patterns and LEDs
module tb_alert_driver;

    localparam int TD = 4;
    localparam int BL = 16;
    localparam int GL = 8;

    logic clk_50MHz = 1'b0;
    logic reset = 1'b1;
    logic key_on = 1'b0, key_off = 1'b0, key_err = 1'b0, key_open = 1'b0, key_buzzer = 1'b0;
    logic led_on, led_err, led_open, buzzer_out, busy;

    int vectors = 0;
    int errors = 0;
    logic [1:0] sb[$];
    logic [1:0] exp_v;

    alert_driver #(.TONE_DIV(TD), .BEEP_LEN(BL), .GAP_LEN(GL), .CNT_W(5)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset),
        .key_on(key_on), .key_off(key_off), .key_err(key_err),
        .key_open(key_open), .key_buzzer(key_buzzer),
        .led_on(led_on), .led_err(led_err), .led_open(led_open),
        .buzzer_out(buzzer_out), .busy(busy)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Expected {busy, buzzer_out} per cycle for an n-beep pattern followed by idle cycles
    task automatic push_pattern(input int nb, input int idle);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < BL; i++) sb.push_back({1'b1, ((i / TD) % 2) == 0});
            if (b < nb - 1)
                for (int i = 0; i < GL; i++) sb.push_back(2'b10);
        end
        for (int i = 0; i < idle; i++) sb.push_back(2'b00);
    endtask

    task automatic test_reset;
        @(negedge clk_50MHz);
        vectors++;
        if ({led_on, led_err, led_open, buzzer_out, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 00000", {led_on, led_err, led_open, buzzer_out, busy});
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50MHz);
            vectors++;
            if ({led_on, led_err, led_open, buzzer_out, busy} !== 5'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got %b expected 00000", {led_on, led_err, led_open, buzzer_out, busy});
            end
        end
    endtask

    task automatic test_on_pulse;
        int n;
        key_on = 1'b1;
        push_pattern(1, 6);
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL on_pattern[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            if (n == 0) begin
                vectors++;
                if (led_on !== 1'b1) begin
                    errors++;
                    $display("FAIL on_led: got %b expected 1", led_on);
                end
            end
            if (n == 2) key_on = 1'b0;
            n++;
        end
    endtask

    task automatic test_off;
        int n;
        key_off = 1'b1;
        push_pattern(2, 4);
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL off_pattern[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            if (n == 0) begin
                vectors++;
                if (led_on !== 1'b0) begin
                    errors++;
                    $display("FAIL off_led: got %b expected 0", led_on);
                end
            end
            if (n == 1) key_off = 1'b0;
            n++;
        end
    endtask

    task automatic test_err_preempt;
        int n;
        key_off = 1'b1;
        for (int i = 0; i < 5; i++) sb.push_back({1'b1, ((i / TD) % 2) == 0});
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL pre_err[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            n++;
        end
        key_off = 1'b0;
        key_err = 1'b1;
        push_pattern(3, 4);
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL err_pattern[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            if (n == 0) begin
                vectors++;
                if (led_err !== 1'b1) begin
                    errors++;
                    $display("FAIL err_led: got %b expected 1", led_err);
                end
            end
            if (n == 3) key_err = 1'b0;
            n++;
        end
    endtask

    task automatic test_simultaneous;
        int n;
        key_on = 1'b1;
        push_pattern(1, 2);
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL relight_pattern: got %b expected %b", {busy, buzzer_out}, exp_v);
            end
        end
        key_on = 1'b0;
        @(negedge clk_50MHz);
        vectors++;
        if (led_on !== 1'b1 || led_err !== 1'b1) begin
            errors++;
            $display("FAIL pre_sim_leds: got on=%b err=%b expected on=1 err=1", led_on, led_err);
        end
        key_on = 1'b1;
        key_off = 1'b1;
        push_pattern(2, 6);
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL sim_pattern[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            if (n == 0) begin
                vectors++;
                if (led_on !== 1'b0 || led_err !== 1'b0) begin
                    errors++;
                    $display("FAIL sim_leds: got on=%b err=%b expected on=0 err=0", led_on, led_err);
                end
            end
            if (n == 2) begin
                key_on = 1'b0;
                key_off = 1'b0;
            end
            if (n == 20) key_buzzer = 1'b1;
            if (n == 24) key_buzzer = 1'b0;
            n++;
        end
    endtask

    task automatic test_open_and_hold;
        int n;
        key_open = 1'b1;
        #1;
        vectors++;
        if (led_open !== 1'b0) begin
            errors++;
            $display("FAIL open_early: got %b expected 0", led_open);
        end
        @(negedge clk_50MHz);
        vectors++;
        if (led_open !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL open_rise: got open=%b busy=%b expected open=1 busy=0", led_open, busy);
        end
        key_open = 1'b0;
        #1;
        vectors++;
        if (led_open !== 1'b1) begin
            errors++;
            $display("FAIL open_hold: got %b expected 1", led_open);
        end
        @(negedge clk_50MHz);
        vectors++;
        if (led_open !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL open_fall: got open=%b busy=%b expected open=0 busy=0", led_open, busy);
        end
        key_err = 1'b1;
        push_pattern(3, 100 - (3 * BL + 2 * GL));
        n = 0;
        while (sb.size() > 0) begin
            @(negedge clk_50MHz);
            exp_v = sb.pop_front();
            vectors++;
            if ({busy, buzzer_out} !== exp_v) begin
                errors++;
                $display("FAIL err_hold[%0d]: got %b expected %b", n, {busy, buzzer_out}, exp_v);
            end
            n++;
        end
        vectors++;
        if (led_err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold_led: got %b expected 1", led_err);
        end
        key_err = 1'b0;
        @(negedge clk_50MHz);
    endtask

    task automatic test_reset_mid_beep;
        key_on = 1'b1;
        @(negedge clk_50MHz);
        @(negedge clk_50MHz);
        @(posedge clk_50MHz);
        #2;
        vectors++;
        if (buzzer_out !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: got buzzer=%b busy=%b expected 1 1", buzzer_out, busy);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({led_on, led_err, led_open, buzzer_out, busy} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 00000", {led_on, led_err, led_open, buzzer_out, busy});
        end
        key_on = 1'b0;
        @(negedge clk_50MHz);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50MHz);
            vectors++;
            if ({led_on, led_err, led_open, buzzer_out, busy} !== 5'b0) begin
                errors++;
                $display("FAIL after_abort[%0d]: got %b expected 00000", i, {led_on, led_err, led_open, buzzer_out, busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_on_pulse();
        test_off();
        test_err_preempt();
        test_simultaneous();
        test_open_and_hold();
        test_reset_mid_beep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
